wb_stage_pipe: RTL and testbench

- Parametrised MEM/WB pipeline register and writeback stage for the pipelined MIPS core.
- Latches results leaving the memory stage and selects the register-file write value from three sources: ALU result, load data or link PC.
- Extracts byte and halfword loads, with sign or zero extension.
- Supports stall and flush, suppresses writes to register $0, and counts retired instructions.

---
 rtl/wb_stage_pipe_if.sv | 38 +++
 rtl/wb_stage_pipe.sv | 97 +++++++++
 tb/tb_wb_stage_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pipe_if.sv
// rtl/wb_stage_pipe_if.sv - MEM/WB stage bus: memory-stage inputs, control and writeback outputs
interface wb_stage_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) ();
    logic                  mem_valid;
    logic                  wb_stall;
    logic                  wb_flush;
    logic                  mem_regwrite;
    logic [1:0]            mem_wbsel;
    logic [1:0]            mem_ldsize;
    logic                  mem_ldsigned;
    logic [2:0]            mem_addr_lo;
    logic [DATA_W-1:0]     mem_read_data;
    logic [DATA_W-1:0]     mem_alu_result;
    logic [DATA_W-1:0]     mem_link_pc;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  wb_valid;
    logic                  wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]     wb_writedata;
    logic [CNT_W-1:0]      retire_count;

    // Pipeline side driving the memory-stage results into the WB register
    modport master (
        output mem_valid, wb_stall, wb_flush, mem_regwrite, mem_wbsel, mem_ldsize,
               mem_ldsigned, mem_addr_lo, mem_read_data, mem_alu_result, mem_link_pc, mem_dest,
        input  wb_valid, wb_regwrite, wb_dest, wb_writedata, retire_count
    );

    // WB stage itself
    modport slave (
        input  mem_valid, wb_stall, wb_flush, mem_regwrite, mem_wbsel, mem_ldsize,
               mem_ldsigned, mem_addr_lo, mem_read_data, mem_alu_result, mem_link_pc, mem_dest,
        output wb_valid, wb_regwrite, wb_dest, wb_writedata, retire_count
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - MEM/WB pipeline register with load formatting, writeback select and retire counter
module wb_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic           clk,
    input  logic           rst,
    wb_stage_pipe_if.slave bus
);
    // Load extraction is done on a 64-bit view so one datapath serves both widths;
    // the result is truncated back to DATA_W.
    logic [63:0]             w_rd64;
    logic [2:0]              w_lane;
    logic [1:0]              w_half;
    logic                    w_word_sel;
    logic [63:0]             w_shift;
    logic [63:0]             w_ld64;
    logic [DATA_W-1:0]       w_load;
    logic [DATA_W-1:0]       w_wdata;
    logic                    w_regwrite;

    logic                    r_wb_valid;
    logic                    r_wb_regwrite;
    logic [REG_ADDR_W-1:0]   r_wb_dest;
    logic [DATA_W-1:0]       r_wb_writedata;
    logic [CNT_W-1:0]        r_retire_count;

    // Select the addressed byte/half/word lane and extend it to the datapath width
    always_comb begin
        w_rd64                = '0;
        w_rd64[DATA_W-1:0]    = bus.mem_read_data;
        // On a 32-bit datapath the upper address bit names no lane and is masked off
        w_lane     = (DATA_W == 32) ? {1'b0, bus.mem_addr_lo[1:0]} : bus.mem_addr_lo;
        w_half     = w_lane[2:1];
        w_word_sel = (DATA_W == 64) && bus.mem_addr_lo[2];
        w_shift    = w_rd64;
        w_ld64     = w_rd64;
        case (bus.mem_ldsize)
            2'b00: begin
                w_shift = w_rd64 >> {w_lane, 3'b000};
                w_ld64  = {{56{bus.mem_ldsigned & w_shift[7]}}, w_shift[7:0]};
            end
            2'b01: begin
                w_shift = w_rd64 >> {w_half, 4'b0000};
                w_ld64  = {{48{bus.mem_ldsigned & w_shift[15]}}, w_shift[15:0]};
            end
            2'b10: begin
                w_shift = w_rd64 >> {w_word_sel, 5'b00000};
                w_ld64  = {{32{bus.mem_ldsigned & w_shift[31]}}, w_shift[31:0]};
            end
            default: begin
                w_shift = w_rd64;
                w_ld64  = w_shift;
            end
        endcase
        w_load = w_ld64[DATA_W-1:0];
    end

    // Writeback source mux and register-write qualification ($0 is never written)
    always_comb begin
        case (bus.mem_wbsel)
            2'b01:   w_wdata = w_load;
            2'b10:   w_wdata = bus.mem_link_pc;
            default: w_wdata = bus.mem_alu_result;
        endcase
        w_regwrite = bus.mem_valid & bus.mem_regwrite & (bus.mem_dest != '0);
    end

    // Pipeline register: flush beats stall beats capture; retire counts captured valid slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_dest      <= '0;
            r_wb_writedata <= '0;
            r_retire_count <= '0;
        end else if (bus.wb_flush) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
        end else if (!bus.wb_stall) begin
            r_wb_valid     <= bus.mem_valid;
            r_wb_regwrite  <= w_regwrite;
            r_wb_dest      <= bus.mem_dest;
            r_wb_writedata <= w_wdata;
            if (bus.mem_valid) begin
                r_retire_count <= r_retire_count + CNT_W'(1);
            end
        end
    end

    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_regwrite  = r_wb_regwrite;
    assign bus.wb_dest      = r_wb_dest;
    assign bus.wb_writedata = r_wb_writedata;
    assign bus.retire_count = r_retire_count;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - scoreboard bench for wb_stage_pipe at DATA_W=32 and DATA_W=64
module tb_wb_stage_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_valid, s_stall, s_flush, s_rw, s_sg;
    logic [1:0]  s_sel, s_sz;
    logic [2:0]  s_ad;
    logic [63:0] s_rd, s_alu, s_link;
    logic [4:0]  s_dst;

    wb_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) if32 ();
    wb_stage_pipe_if #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(4)) if64 ();

    assign if32.mem_valid = s_valid;       assign if64.mem_valid = s_valid;
    assign if32.wb_stall = s_stall;        assign if64.wb_stall = s_stall;
    assign if32.wb_flush = s_flush;        assign if64.wb_flush = s_flush;
    assign if32.mem_regwrite = s_rw;       assign if64.mem_regwrite = s_rw;
    assign if32.mem_wbsel = s_sel;         assign if64.mem_wbsel = s_sel;
    assign if32.mem_ldsize = s_sz;         assign if64.mem_ldsize = s_sz;
    assign if32.mem_ldsigned = s_sg;       assign if64.mem_ldsigned = s_sg;
    assign if32.mem_addr_lo = s_ad;        assign if64.mem_addr_lo = s_ad;
    assign if32.mem_read_data = s_rd[31:0];   assign if64.mem_read_data = s_rd;
    assign if32.mem_alu_result = s_alu[31:0]; assign if64.mem_alu_result = s_alu;
    assign if32.mem_link_pc = s_link[31:0];   assign if64.mem_link_pc = s_link;
    assign if32.mem_dest = s_dst;          assign if64.mem_dest = s_dst;

    wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    wb_stage_pipe #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(4)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [4:0]  dest;
        logic [63:0] data;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t m32, m64;
    int total = 0;
    int bad = 0;

    function automatic logic [63:0] fmt(input bit is64);
        int nb, pos, a;
        logic [63:0] w, mask, f, r;
        a = is64 ? int'(s_ad) : int'(s_ad) % 4;
        w = is64 ? s_rd : (s_rd & 64'hFFFF_FFFF);
        case (s_sz)
            2'b00:   begin nb = 8;  pos = a * 8; end
            2'b01:   begin nb = 16; pos = (a / 2) * 16; end
            2'b10:   begin nb = 32; pos = is64 ? (int'(s_ad) / 4) * 32 : 0; end
            default: begin nb = is64 ? 64 : 32; pos = 0; end
        endcase
        mask = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
        f = (w >> pos) & mask;
        if (s_sg && f[nb-1]) f = f | ~mask;
        case (s_sel)
            2'b01:   r = f;
            2'b10:   r = s_link;
            default: r = s_alu;
        endcase
        if (!is64) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    function automatic exp_t step(input exp_t m, input bit is64);
        exp_t n = m;
        if (s_flush) begin
            n.v = 1'b0;
            n.rw = 1'b0;
        end else if (!s_stall) begin
            n.v = s_valid;
            n.rw = s_valid && s_rw && (s_dst != 5'd0);
            n.dest = s_dst;
            n.data = fmt(is64);
            if (s_valid) n.cnt = m.cnt + 4'd1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [1:0] sz,
                         input logic sg, input logic [2:0] ad, input logic [63:0] rd,
                         input logic [63:0] alu, input logic [63:0] link, input logic [4:0] dst,
                         input logic st, input logic fl);
        @(negedge clk);
        rst = 1'b1;
        s_valid = v; s_rw = rw; s_sel = sel; s_sz = sz; s_sg = sg; s_ad = ad;
        s_rd = rd; s_alu = alu; s_link = link; s_dst = dst; s_stall = st; s_flush = fl;
        m32 = step(m32, 1'b0);
        m64 = step(m64, 1'b1);
        q32.push_back(m32);
        q64.push_back(m64);
    endtask

    task automatic rdrive();
        drive(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 3'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    endtask

    // Asynchronous reset dropped between edges while a stall is in progress
    task automatic reset_pulse();
        @(negedge clk);
        s_valid = 1'b1; s_rw = 1'b1; s_stall = 1'b1; s_flush = 1'($urandom);
        s_dst = 5'($urandom); s_alu = {$urandom, $urandom};
        #2 rst = 1'b0;
        #1;
        chk("async_rst32", {if32.wb_valid, if32.wb_regwrite, if32.wb_dest, if32.wb_writedata, if32.retire_count}, 64'd0);
        chk("async_rst64_data", if64.wb_writedata, 64'd0);
        chk("async_rst64_ctl", {if64.wb_valid, if64.wb_regwrite, if64.wb_dest, if64.retire_count}, 64'd0);
        m32 = '0;
        m64 = '0;
        q32.push_back(m32);
        q64.push_back(m64);
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expected entry per clock edge for each instance
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q32.size() > 0) begin
                e = q32.pop_front();
                a = {if32.wb_valid, if32.wb_regwrite, if32.wb_dest, 32'h0, if32.wb_writedata, if32.retire_count};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL sb32 actual=%h expected=%h", a, e);
                end
            end
            if (q64.size() > 0) begin
                e = q64.pop_front();
                a = {if64.wb_valid, if64.wb_regwrite, if64.wb_dest, if64.wb_writedata, if64.retire_count};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL sb64 actual=%h expected=%h", a, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        s_valid = 1'b1; s_stall = 1'b0; s_flush = 1'b0; s_rw = 1'b1; s_sg = 1'b0;
        s_sel = 2'b00; s_sz = 2'b00; s_ad = 3'd0;
        s_rd = 64'd0; s_alu = 64'h55; s_link = 64'd0; s_dst = 5'd3;
        m32 = '0;
        m64 = '0;
        repeat (3) @(negedge clk);
        chk("reset32", {if32.wb_valid, if32.wb_regwrite, if32.wb_dest, if32.wb_writedata, if32.retire_count}, 64'd0);
        chk("reset64", if64.wb_writedata | 64'({if64.wb_valid, if64.wb_regwrite, if64.wb_dest, if64.retire_count}), 64'd0);

        drive(1, 1, 2'b00, 2'b00, 0, 3'd0, 64'd0, 64'h0000_1234, 64'd0, 5'd8, 0, 0);
        peek();
        chk("alu_data", if32.wb_writedata, 64'h1234);
        chk("alu_ctl", {if32.wb_regwrite, if32.wb_dest, if32.retire_count}, {1'b1, 5'd8, 4'd1});

        drive(1, 1, 2'b01, 2'b00, 1, 3'd3, 64'h80FF_7F01, 64'd0, 64'd0, 5'd5, 0, 0);
        peek();
        chk("lb_signed", if32.wb_writedata, 64'hFFFF_FF80);

        drive(1, 1, 2'b01, 2'b00, 0, 3'd2, 64'h80FF_7F01, 64'd0, 64'd0, 5'd5, 0, 0);
        peek();
        chk("lbu", if32.wb_writedata, 64'h0000_00FF);

        drive(1, 1, 2'b01, 2'b01, 1, 3'd2, 64'h8001_0000, 64'd0, 64'd0, 5'd6, 0, 0);
        peek();
        chk("lh_signed", if32.wb_writedata, 64'hFFFF_8001);

        drive(1, 1, 2'b10, 2'b00, 0, 3'd0, 64'd0, 64'd0, 64'h0040_0008, 5'd31, 0, 0);
        peek();
        chk("link", {if32.wb_dest, if32.wb_writedata}, {5'd31, 32'h0040_0008});

        drive(1, 1, 2'b00, 2'b00, 0, 3'd0, 64'd0, 64'hDEAD_0000, 64'd0, 5'd0, 0, 0);
        peek();
        chk("r0_suppress", {if32.wb_valid, if32.wb_regwrite, if32.retire_count}, {1'b1, 1'b0, 4'd6});

        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'b00, 2'b00, 0, 3'd0, 64'd0, 64'($urandom), 64'd0, 5'(i + 1), 1, 0);
            peek();
            chk("stall_hold", {if32.wb_valid, if32.wb_dest, if32.wb_writedata, if32.retire_count},
                {1'b1, 5'd0, 32'hDEAD_0000, 4'd6});
        end

        drive(1, 1, 2'b00, 2'b00, 0, 3'd0, 64'd0, 64'h77, 64'd0, 5'd9, 1, 1);
        peek();
        chk("flush_over_stall", {if32.wb_valid, if32.wb_regwrite, if32.wb_writedata, if32.retire_count},
            {1'b0, 1'b0, 32'hDEAD_0000, 4'd6});

        reset_pulse();
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 2'b00, 2'b00, 0, 3'd0, 64'd0, 64'(i), 64'd0, 5'd4, 0, 0);
        end
        peek();
        chk("wrap17", if32.retire_count, 64'd1);
        chk("wrap17_64", if64.retire_count, 64'd1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) reset_pulse();
            else rdrive();
        end
        peek();
        peek();
        chk("queues_drained", 64'(q32.size() + q64.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
